// File: rtl/chunk_serial_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder/subtractor.
package chunk_serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Chunk counter width; at least one bit so NCHUNK=1 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_serial_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from per-bit full adders.
module adder_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cmsb
);

    always_comb begin
        logic c;
        s    = '0;
        cmsb = 1'b0;
        c    = ci;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (i == int'(CHUNK) - 1) begin
                cmsb = c;
            end
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH bits, CHUNK bits per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by CHUNK_SERIAL_ADDER_OVF_EN.
module chunk_serial_adder
    import chunk_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = cnt_width(NCHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;

    int unsigned      base;
    logic             last;
    logic [CHUNK-1:0] slice_x;
    logic [CHUNK-1:0] slice_y;
    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    logic             slice_cmsb;
`else
    logic             slice_cmsb_unused;
`endif

    assign base    = int'(cnt_q) * CHUNK;
    assign last    = (cnt_q == CW'(NCHUNK - 1));
    assign slice_x = a_q[base +: CHUNK];
    assign slice_y = b_q[base +: CHUNK];

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .ci   (carry_q),
        .s    (slice_s),
        .co   (slice_co),
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        .cmsb (slice_cmsb)
`else
        .cmsb (slice_cmsb_unused)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        // Subtract folds into the add as a + ~b + 1.
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        carry_q  <= sub ? 1'b1 : cin;
                        cnt_q    <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    sum[base +: CHUNK] <= slice_s;
                    carry_q            <= slice_co;
                    if (last) begin
                        cout      <= slice_co;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
                        ovf       <= slice_co ^ slice_cmsb;
`endif
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Randomised self-checking bench for chunk_serial_adder (32/8 and 16/16 instances).
module tb_chunk_serial_adder;

    localparam int unsigned W  = 32;
    localparam int unsigned C  = 8;
    localparam int unsigned NC = W / C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0]  a, b, sum;
    logic          n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready, n_cout;
    logic [15:0]   n_a, n_b, n_sum;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    logic          ovf, n_ovf;
`endif

    int checks = 0;
    int errors = 0;

    chunk_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .a         (n_a),
        .b         (n_b),
        .cin       (n_cin),
        .sub       (n_sub),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .sum       (n_sum),
        .cout      (n_cout)
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (n_ovf)
`endif
    );

    // Reference: plain unsigned arithmetic; overflow from operand/result signs.
    task automatic model(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin,
                         input logic tsub, output logic [31:0] es, output logic ec,
                         output logic eo);
        logic [32:0] full;
        if (tsub) begin
            es = ta - tb_;
            ec = (ta >= tb_);
            eo = (ta[31] != tb_[31]) && (es[31] != ta[31]);
        end else begin
            full = {1'b0, ta} + {1'b0, tb_} + {32'd0, tcin};
            es   = full[31:0];
            ec   = full[32];
            eo   = (ta[31] == tb_[31]) && (es[31] != ta[31]);
        end
    endtask

    // Launch one operation and wait (bounded) for out_valid; optionally toggles junk inputs while busy.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin,
                          input logic tsub, input logic junk, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        if (junk) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        n_in_valid = 1'b0; n_out_ready = 1'b0; n_a = '0; n_b = '0; n_cin = 1'b0; n_sub = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 32'd0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL reset_n_in_ready: got %b want 1", n_in_ready); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'd5, 32'd7};
        logic [31:0] vb [3] = '{32'h0000_0001, 32'd7, 32'd5};
        logic        vc [3] = '{1'b0, 1'b1, 1'b1};
        logic        vs [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] ws [3] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0002};
        logic        wc [3] = '{1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], vs[i], 1'b0, lat);
            checks++; if (lat != int'(NC)) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, NC); end
            checks++; if (sum !== ws[i]) begin errors++; $display("FAIL dir_sum[%0d]: got %h want %h", i, sum, ws[i]); end
            checks++; if (cout !== wc[i]) begin errors++; $display("FAIL dir_cout[%0d]: got %b want %b", i, cout, wc[i]); end
            consume();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL dir_handover[%0d]: out_valid %b in_ready %b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ta, tb_, es;
        logic tc, ts, ec, eo;
        int lat;
        for (int i = 0; i < 24; i++) begin
            ta = $urandom; tb_ = $urandom; tc = 1'($urandom); ts = 1'($urandom);
            if (i % 6 == 0) tb_ = ta;
            model(ta, tb_, tc, ts, es, ec, eo);
            run_op(ta, tb_, tc, ts, (i % 2 == 1), lat);
            checks++; if (lat != int'(NC)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, NC); end
            checks++; if (sum !== es) begin errors++; $display("FAIL rnd_sum[%0d]: got %h want %h (a=%h b=%h cin=%b sub=%b)", i, sum, es, ta, tb_, tc, ts); end
            checks++; if (cout !== ec) begin errors++; $display("FAIL rnd_cout[%0d]: got %b want %b", i, cout, ec); end
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
            checks++; if (ovf !== eo) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, ovf, eo); end
`endif
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ta, tb_, es;
        logic ec, eo;
        int lat;
        ta = $urandom; tb_ = $urandom;
        model(ta, tb_, 1'b1, 1'b0, es, ec, eo);
        run_op(ta, tb_, 1'b1, 1'b0, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es || cout !== ec) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ov=%b ir=%b sum=%h cout=%b want 1/0/%h/%b", i, out_valid, in_ready, sum, cout, es, ec);
            end
        end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        int lat;
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        checks++; if (sum !== 32'd0) begin errors++; $display("FAIL rstmid_sum: got %h want 0", sum); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; seen |= out_valid;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_ghost: out_valid seen %b want 0", seen); end
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, lat);
        checks++; if (sum !== 32'h2345_6789 || lat != int'(NC)) begin
            errors++; $display("FAIL rstmid_next: sum %h lat %0d want 23456789 %0d", sum, lat, NC);
        end
        consume();
    endtask

`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        int lat;
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, lat);
        checks++; if (ovf !== 1'b1 || sum !== 32'h8000_0000) begin
            errors++; $display("FAIL ovf_pos: ovf %b sum %h want 1 80000000", ovf, sum);
        end
        consume();
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, lat);
        checks++; if (ovf !== 1'b0 || cout !== 1'b1) begin
            errors++; $display("FAIL ovf_neg: ovf %b cout %b want 0 1", ovf, cout);
        end
        consume();
    endtask
`endif

    task automatic test_narrow();
        logic [15:0] ta, tb_, es;
        logic [16:0] full;
        logic tc, ts, ec;
        int lat;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                ta = 16'hFFFF; tb_ = 16'hFFFF; tc = 1'b1; ts = 1'b0;
            end else begin
                ta = 16'($urandom); tb_ = 16'($urandom); tc = 1'($urandom); ts = 1'($urandom);
            end
            if (ts) begin
                es = ta - tb_; ec = (ta >= tb_);
            end else begin
                full = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc}; es = full[15:0]; ec = full[16];
            end
            n_a = ta; n_b = tb_; n_cin = tc; n_sub = ts; n_in_valid = 1'b1;
            @(posedge clk); #1; n_in_valid = 1'b0;
            lat = 0;
            while (!n_out_valid && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            checks++; if (lat != 1 || n_sum !== es || n_cout !== ec) begin
                errors++; $display("FAIL narrow[%0d]: lat %0d sum %h cout %b want 1 %h %b", i, lat, n_sum, n_cout, es, ec);
            end
            n_out_ready = 1'b1;
            @(posedge clk); #1; n_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_narrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
